// File: rtl/alu_pkg.sv
// Shared RV32 ALU definitions: operand width, funct encodings and the operation bundle.
package alu_pkg;
  localparam int XLEN    = 32;
  localparam int NUM_REQ = 2;

  // funct[2:0] selects the operation class, funct[3] picks SUB / SRA
  typedef enum logic [3:0] {
    FN_ADD  = 4'b0000,
    FN_SLL  = 4'b0001,
    FN_SLT  = 4'b0010,
    FN_SLTU = 4'b0011,
    FN_XOR  = 4'b0100,
    FN_SRL  = 4'b0101,
    FN_OR   = 4'b0110,
    FN_AND  = 4'b0111,
    FN_SUB  = 4'b1000,
    FN_SRA  = 4'b1101
  } funct_e;

  typedef struct packed {
    logic [XLEN-1:0] lhs;
    logic [XLEN-1:0] rhs;
    logic [3:0]      funct;
  } alu_op_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU requesters and the shared ALU arbiter.
interface alu_arbiter_if #(parameter int TAG_W = 4);
  import alu_pkg::*;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [XLEN-1:0]    req_lhs0, req_lhs1;
  logic [XLEN-1:0]    req_rhs0, req_rhs1;
  logic [3:0]         req_funct0, req_funct1;
  logic [TAG_W-1:0]   req_tag0, req_tag1;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [NUM_REQ-1:0] rsp_ready;
  logic [XLEN-1:0]    rsp_data;
  logic [TAG_W-1:0]   rsp_tag;

  modport master (
    output req_valid, req_lhs0, req_lhs1, req_rhs0, req_rhs1,
           req_funct0, req_funct1, req_tag0, req_tag1, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag
  );
  modport slave (
    input  req_valid, req_lhs0, req_lhs1, req_rhs0, req_rhs1,
           req_funct0, req_funct1, req_tag0, req_tag1, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Team RV32 integer ALU, purely combinational.
module alu_arbiter_alu
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] lhs,
  input  logic [XLEN-1:0] rhs,
  input  logic [3:0]      funct,
  output logic [XLEN-1:0] y
);
  logic [4:0] shamt;
  assign shamt = rhs[4:0];

  always_comb begin
    y = '0;
    unique case (funct[2:0])
      3'b000: y = funct[3] ? lhs - rhs : lhs + rhs;
      3'b001: y = lhs << shamt;
      3'b010: y = {{(XLEN-1){1'b0}}, $signed(lhs) < $signed(rhs)};
      3'b011: y = {{(XLEN-1){1'b0}}, lhs < rhs};
      3'b100: y = lhs ^ rhs;
      3'b101: y = funct[3] ? XLEN'($signed(lhs) >>> shamt) : lhs >> shamt;
      3'b110: y = lhs | rhs;
      3'b111: y = lhs & rhs;
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; single tagged result register.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter bit RR_INIT = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  alu_arbiter_if.slave bus
);
  alu_op_t [NUM_REQ-1:0]            req_op;
  logic    [NUM_REQ-1:0][TAG_W-1:0] req_tag;
  alu_op_t                          issue_op;
  logic    [NUM_REQ-1:0]            grant;
  logic    [XLEN-1:0]               alu_y, out_data;
  logic    [TAG_W-1:0]              out_tag;
  logic                             out_valid, out_owner, prio, free, sel;

  assign req_op[0]  = '{lhs: bus.req_lhs0, rhs: bus.req_rhs0, funct: bus.req_funct0};
  assign req_op[1]  = '{lhs: bus.req_lhs1, rhs: bus.req_rhs1, funct: bus.req_funct1};
  assign req_tag[0] = bus.req_tag0;
  assign req_tag[1] = bus.req_tag1;

  // Slot frees when its holder consumes it, so drain and refill share a cycle
  assign free = !out_valid || bus.rsp_ready[out_owner];

  always_comb begin
    grant = '0;
    if (free) grant = (&bus.req_valid) ? (prio ? 2'b10 : 2'b01) : bus.req_valid;
  end

  assign sel      = grant[1];
  assign issue_op = req_op[sel];

  alu_arbiter_alu u_alu (
    .lhs   (issue_op.lhs),
    .rhs   (issue_op.rhs),
    .funct (issue_op.funct),
    .y     (alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_owner <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      prio      <= RR_INIT;
    end else if (|grant) begin
      out_valid <= 1'b1;
      out_owner <= sel;
      out_data  <= alu_y;
      out_tag   <= req_tag[sel];
      prio      <= !sel;
    end else if (free) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.req_ready = rst_n ? grant : '0;
  assign bus.rsp_valid = {out_valid && out_owner, out_valid && !out_owner};
  assign bus.rsp_data  = out_data;
  assign bus.rsp_tag   = out_tag;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_alu_arbiter;
  localparam int TAG_W   = 4;
  localparam bit RR_INIT = 1'b0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.TAG_W(TAG_W)) bus ();
  alu_arbiter #(.TAG_W(TAG_W), .RR_INIT(RR_INIT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    logic signed [31:0] sa;
    sh = b[4:0];
    sa = a;
    case (f)
      4'd0:  return a + b;
      4'd8:  return a - b;
      4'd1:  return a << sh;
      4'd2:  return (sa < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:  return (a < b) ? 32'd1 : 32'd0;
      4'd4:  return a ^ b;
      4'd5:  return a >> sh;
      4'd13: return sa >>> sh;
      4'd6:  return a | b;
      4'd7:  return a & b;
      default: return 32'd0;
    endcase
  endfunction

  // Reference: one result slot, a tie-break pointer, and the grant rule
  logic        m_valid = 1'b0, m_owner = 1'b0, m_prio = RR_INIT;
  logic [31:0] m_data = '0;
  logic [3:0]  m_tag = '0;
  logic [1:0]  last_grant = '0;

  function automatic logic [1:0] exp_grant();
    if (m_valid && !bus.rsp_ready[m_owner]) return 2'b00;
    if (bus.req_valid == 2'b11) return m_prio ? 2'b10 : 2'b01;
    return bus.req_valid;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_prio = RR_INIT; m_data = '0; m_tag = '0; last_grant = '0;
    end else begin
      last_grant = exp_grant();
      if (last_grant == 2'b01) begin
        m_valid = 1'b1; m_owner = 1'b0; m_prio = 1'b1;
        m_data = alu_ref(bus.req_funct0, bus.req_lhs0, bus.req_rhs0); m_tag = bus.req_tag0;
      end else if (last_grant == 2'b10) begin
        m_valid = 1'b1; m_owner = 1'b1; m_prio = 1'b0;
        m_data = alu_ref(bus.req_funct1, bus.req_lhs1, bus.req_rhs1); m_tag = bus.req_tag1;
      end else if (m_valid && bus.rsp_ready[m_owner]) begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rsp_data", bus.rsp_data, 32'd0);
      chk("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
    end else begin
      chk("req_ready", 32'(bus.req_ready), 32'(exp_grant()));
      chk("rsp_valid", 32'(bus.rsp_valid), m_valid ? (m_owner ? 32'd2 : 32'd1) : 32'd0);
      if (m_valid) begin
        chk("rsp_data", bus.rsp_data, m_data);
        chk("rsp_tag", 32'(bus.rsp_tag), 32'(m_tag));
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic drive(input int k, input logic [3:0] f, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    if (k == 0) begin
      bus.req_funct0 = f; bus.req_lhs0 = a; bus.req_rhs0 = b; bus.req_tag0 = t;
    end else begin
      bus.req_funct1 = f; bus.req_lhs1 = a; bus.req_rhs1 = b; bus.req_tag1 = t;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
  endtask

  // One isolated operation on port k with a literal expected result
  task automatic op(input string name, input int k, input logic [3:0] f, input logic [31:0] a,
                    input logic [31:0] b, input logic [3:0] t, input logic [31:0] exp);
    logic [1:0] pv;
    pv = 2'b01 << k;
    drive(k, f, a, b, t); bus.req_valid = pv;
    @(negedge clk); chk({name, "_ready"}, 32'(bus.req_ready), 32'(pv));
    tick(); bus.req_valid = 2'b00;
    @(negedge clk);
    chk({name, "_valid"}, 32'(bus.rsp_valid), 32'(pv));
    chk({name, "_data"}, bus.rsp_data, exp);
    chk({name, "_tag"}, 32'(bus.rsp_tag), 32'(t));
    tick();
  endtask

  initial begin
    bus.req_valid = '0; bus.rsp_ready = 2'b11;
    drive(0, 4'd0, '0, '0, '0); drive(1, 4'd0, '0, '0, '0);
    tick(); tick(); rst_n = 1'b1;

    // Contention straight out of reset: 0,1,0,1
    drive(0, 4'd0, 32'd1, 32'd1, 4'hA); drive(1, 4'd0, 32'd10, 32'd10, 4'h5);
    bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cont_grant", 32'(bus.req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
      if (i > 0) chk("cont_rsp", 32'(bus.rsp_valid), (i % 2 == 0) ? 32'd2 : 32'd1);
      tick();
    end
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("cont_last_valid", 32'(bus.rsp_valid), 32'd2);
    chk("cont_last_tag", 32'(bus.rsp_tag), 32'h5);
    chk("cont_last_data", bus.rsp_data, 32'd20);
    tick();

    op("add",  0, 4'd0,  32'd5,        32'd7,  4'd3, 32'd12);
    op("sub",  1, 4'd8,  32'd10,       32'd3,  4'd1, 32'd7);
    op("sra",  0, 4'd13, 32'h80000000, 32'd4,  4'd2, 32'hF8000000);
    op("srl",  1, 4'd5,  32'h80000000, 32'd4,  4'd4, 32'h08000000);
    op("slt",  0, 4'd2,  32'hFFFFFFFF, 32'd1,  4'd6, 32'd1);
    op("sltu", 1, 4'd3,  32'hFFFFFFFF, 32'd1,  4'd7, 32'd0);
    op("sll",  0, 4'd1,  32'd1,        32'd33, 4'd8, 32'd2);

    // Backpressure on port 0 while port 1 waits
    bus.rsp_ready = 2'b10;
    drive(0, 4'd0, 32'd5, 32'd7, 4'd3); bus.req_valid = 2'b01;
    @(negedge clk); chk("bp_grant0", 32'(bus.req_ready), 32'd1);
    tick();
    drive(1, 4'd8, 32'd100, 32'd1, 4'd9); bus.req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_hold_data", bus.rsp_data, 32'd12);
      tick();
    end
    bus.rsp_ready = 2'b11;
    @(negedge clk); chk("bp_release_grant", 32'(bus.req_ready), 32'd2);
    tick(); bus.req_valid = 2'b00;
    @(negedge clk);
    chk("bp_p1_valid", 32'(bus.rsp_valid), 32'd2);
    chk("bp_p1_data", bus.rsp_data, 32'd99);
    chk("bp_p1_tag", 32'(bus.rsp_tag), 32'd9);
    tick();

    // Back-to-back on port 1
    bus.req_valid = 2'b10;
    for (int i = 0; i < 8; i++) begin
      drive(1, 4'd0, 32'(i * 100), 32'(i), 4'(i));
      @(negedge clk);
      chk("b2b_grant", 32'(bus.req_ready), 32'd2);
      if (i > 0) begin
        chk("b2b_valid", 32'(bus.rsp_valid), 32'd2);
        chk("b2b_data", bus.rsp_data, 32'((i - 1) * 101));
        chk("b2b_tag", 32'(bus.rsp_tag), 32'(i - 1));
      end
      tick();
    end
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("b2b_last_data", bus.rsp_data, 32'd707);
    chk("b2b_last_tag", 32'(bus.rsp_tag), 32'd7);
    tick();

    // Asynchronous reset with a result pending
    bus.rsp_ready = 2'b00;
    drive(0, 4'd0, 32'd1, 32'd2, 4'd5); bus.req_valid = 2'b01;
    tick(); bus.req_valid = 2'b00;
    #2; chk("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
    rst_n = 1'b0; #1;
    chk("async_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("async_rst_ready", 32'(bus.req_ready), 32'd0);
    chk("async_rst_data", bus.rsp_data, 32'd0);
    tick(); rst_n = 1'b1; bus.rsp_ready = 2'b11;
    drive(1, 4'd0, 32'd3, 32'd4, 4'd6); bus.req_valid = 2'b11;
    @(negedge clk); chk("post_rst_prio", 32'(bus.req_ready), RR_INIT ? 32'd2 : 32'd1);
    tick(); bus.req_valid = 2'b00; tick(); tick();

    // Randomized traffic: hold until accepted, occasional drop
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!bus.req_valid[k] || last_grant[k]) begin
          int fi;
          logic [3:0] fl [10];
          fl = '{4'd0, 4'd8, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd13, 4'd6, 4'd7};
          fi = int'($urandom_range(0, 9));
          drive(k, fl[fi], $urandom, ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom,
                4'($urandom));
          bus.req_valid[k] = ($urandom_range(0, 9) < 7);
        end else if ($urandom_range(0, 15) == 0) begin
          bus.req_valid[k] = 1'b0;
        end
      end
      bus.rsp_ready = 2'($urandom);
      if (c == 1500) begin
        rst_n = 1'b0; tick(); rst_n = 1'b1;
      end
      tick();
    end
    bus.req_valid = 2'b00;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one RV32 integer ALU between two requesters (port 0: EX-stage issue, port 1: address/auxiliary unit). Each port uses valid/ready request and response handshakes. The block does round-robin arbitration, issues the winning operation to a single internal ALU instance, and holds the result in one output register tagged with its owner. Latency is one cycle, and throughput is one operation per cycle while responses drain.

Parameters:
TAG_W, 4, width of the opaque requester tag returned with each result
RR_INIT, 0, requester that holds priority after reset (0 or 1)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  2  per-requester request valid, bit k = requester k
req_ready  out  2  per-requester request accepted this cycle
req_lhs0, req_lhs1  in  32  left operand
req_rhs0, req_rhs1  in  32  right operand, or shift amount in bits [4:0]
req_funct0, req_funct1  in  4  ALU op: [2:0] = ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND; [3] = SUB/SRA modifier
req_tag0, req_tag1  in  TAG_W  tag echoed back with the response
rsp_valid  out  2  response valid, bit k = result belongs to requester k
rsp_ready  in  2  requester k consumes its response
rsp_data  out  32  ALU result, shared by both ports
rsp_tag  out  TAG_W  echoed tag, shared by both ports

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, so rsp_valid=2'b00.
  - rsp_data=0, rsp_tag=0.
  - Priority pointer = RR_INIT.
  - req_ready=2'b00 while rst_n is low.
  - An in-flight result is discarded with no response.
- State:
  - out_valid, out_owner (1 bit), out_data, out_tag.
  - prio (1 bit), which names the requester that wins a tie.
- Slot free:
  - free = !out_valid || rsp_ready[out_owner].
  - Draining the slot and accepting a new request can happen in the same cycle.
- Grant (combinational):
  - If free and exactly one req_valid is set, that requester is granted.
  - If free and both are set, requester prio is granted.
  - req_ready[k] = grant[k]. At most one bit is set.
  - req_ready does not depend on req_valid of the same port beyond the grant rule.
- Issue:
  - The granted operands and funct drive the internal ALU in the same cycle.
  - On the next edge: out_data = ALU result, out_tag = granted tag, out_owner = k, out_valid = 1.
- Latency: a request accepted at edge N has rsp_valid[k] high after edge N, valid in the cycle N to N+1.
- Hold: while rsp_valid[k] is high and rsp_ready[k] is low, rsp_data, rsp_tag and the owner stay stable, and no new grant is made.
- Drain without new grant: out_valid clears on the next edge.
- Pointer update: on any grant to k, prio becomes 1-k. Single grants also flip the pointer, which keeps the arbiter fair.
- Response routing: rsp_valid[k] = out_valid && (out_owner==k). The rsp_ready bit of the non-owner is ignored.
- ALU function, all results 32 bits:
  - ADD/SUB: wraps mod 2^32.
  - SLT (signed) and SLTU (unsigned): result is 0 or 1.
  - SLL, SRL and SRA: use rhs[4:0] only.
  - SRA: sign-fills from lhs[31].
- Requester-side rules (checked by assertions, not by RTL):
  - Once asserted, a request stays stable until it is accepted.
  - A requester may drop req_valid without a handshake; the request is then lost and no response is produced.

Decomposition:
- Shared package alu_pkg:
  - funct encodings FN_ADD=4'b0000, FN_SUB=4'b1000, FN_SLL, FN_SLT, FN_SLTU, FN_XOR, FN_SRL, FN_SRA=4'b1101, FN_OR, FN_AND.
  - Constant XLEN=32.
- Sub-module: the existing team ALU (inputs lhs, rhs, funct; output y), instantiated once.
- The arbiter, output register and pointer live in alu_arbiter.

Test Plan:
- Single op: port0 ADD lhs=5 rhs=7 tag=3, rsp_ready=1 -> next cycle rsp_valid=2'b01, rsp_data=12, rsp_tag=3; req_ready[1]=0 throughout.
- Ops sweep: SUB 10-3 -> 7; SRA 0x80000000,4 -> 0xF8000000; SRL same operands -> 0x08000000; SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0; SLL 1,33 -> 2.
- Contention: both valid for 4 cycles, prio=0 after reset, rsp_ready=2'b11 -> grants 0,1,0,1; responses alternate rsp_valid 01,10,01,10 with matching tags.
- Backpressure: port0 result pending with rsp_ready[0]=0 for 3 cycles and port1 requesting -> req_ready=00, rsp_data stable; when rsp_ready[0] rises, port1 is granted in that same cycle and its result appears next cycle.
- Back-to-back throughput: port1 issues 8 ADDs with rsp_ready=1 -> 8 responses in 8 consecutive cycles, in order, correct tags.
- Reset mid-operation: assert rst_n=0 asynchronously while rsp_valid=01 -> rsp_valid=00 immediately and prio=RR_INIT; after release, the first contended grant goes to RR_INIT.
